// File: rtl/reg_access_sequencer.sv
// reg_access_sequencer: accepts one register-file command at a time, reads the sources,
// writes the destination through an external register file and reports result and carry.
`default_nettype none

module reg_access_sequencer #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] rf_addr_rs1,
  output logic [AW-1:0] rf_addr_rs2,
  input  logic [DW-1:0] rf_rs1,
  input  logic [DW-1:0] rf_rs2,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr_rd,
  output logic [DW-1:0] rf_data,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          res_carry
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_MOV  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [1:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs1_q;
  logic [AW-1:0] rs2_q;
  logic [DW-1:0] result_q;
  logic          carry_q;
  logic [DW-1:0] res_data_q;
  logic          res_carry_q;
  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [DW-1:0] alu_res;
  logic          alu_carry;
  logic          accept;

  assign accept = (state == S_IDLE) && cmd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (cmd_op == OP_LOAD) ? S_WRITE : S_READ;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state == S_IDLE);
    rf_addr_rs1 = (state == S_READ) ? rs1_q : '0;
    rf_addr_rs2 = (state == S_READ) ? rs2_q : '0;
    rf_we       = (state == S_WRITE) && (rd_q != '0);
    rf_addr_rd  = rd_q;
    rf_data     = result_q;
    res_valid   = (state == S_DONE);
    res_data    = res_data_q;
    res_carry   = res_carry_q;
  end

  // Borrow of the unsigned subtract falls out as the extra MSB of the widened difference.
  always_comb begin
    sum       = {1'b0, rf_rs1} + {1'b0, rf_rs2};
    diff      = {1'b0, rf_rs1} - {1'b0, rf_rs2};
    alu_res   = result_q;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD:  begin alu_res = sum[DW-1:0];  alu_carry = sum[DW];  end
      OP_SUB:  begin alu_res = diff[DW-1:0]; alu_carry = diff[DW]; end
      OP_MOV:  alu_res = rf_rs1;
      default: alu_res = result_q;
    endcase
  end

  // The immediate is latched straight into the result register, so LOAD skips READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= OP_LOAD;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q     <= cmd_op;
          rd_q     <= cmd_rd;
          rs1_q    <= cmd_rs1;
          rs2_q    <= cmd_rs2;
          result_q <= cmd_imm;
          carry_q  <= 1'b0;
        end
        S_READ: begin
          result_q <= alu_res;
          carry_q  <= alu_carry;
        end
        S_WRITE: begin
          res_data_q  <= result_q;
          res_carry_q <= carry_q;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_access_sequencer.sv
// tb_reg_access_sequencer: directed commands against a behavioural register file,
// expected results queued at issue time and checked by independent monitors.
`default_nettype none

module tb_reg_access_sequencer;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic [AW-1:0] rf_addr_rs1, rf_addr_rs2, rf_addr_rd;
  logic [DW-1:0] rf_rs1, rf_rs2, rf_data, res_data;
  logic          rf_we, res_valid, res_carry;

  reg_access_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_we(rf_we), .rf_addr_rd(rf_addr_rd), .rf_data(rf_data),
    .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] regs [2**AW];
  initial for (int i = 0; i < 2**AW; i++) regs[i] = '0;
  always @(posedge clk) if (rf_we && rf_addr_rd != '0) regs[rf_addr_rd] <= rf_data;
  assign rf_rs1 = (rf_addr_rs1 == '0) ? '0 : regs[rf_addr_rs1];
  assign rf_rs2 = (rf_addr_rs2 == '0) ? '0 : regs[rf_addr_rs2];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int fails = 0;

  typedef struct { logic [DW-1:0] d; logic c; int acc; int lat; } res_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  res_t res_q[$];
  wr_t  wr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [DW-1:0] last_data = '0;
  logic          last_carry = 1'b0;

  always @(negedge clk) begin : mon_res
    res_t r;
    if (rst) begin last_data = '0; last_carry = 1'b0; end
    if (res_valid) begin
      if (res_q.size() == 0) chk("res_valid_unexpected", 1, 0);
      else begin
        r = res_q.pop_front();
        chk("res_data", res_data, r.d);
        chk("res_carry", res_carry, r.c);
        chk("latency", cyc + 1 - r.acc, r.lat);
        chk("ready_in_done", cmd_ready, 0);
      end
      last_data  = res_data;
      last_carry = res_carry;
    end else begin
      chk("res_data_hold", res_data, last_data);
      chk("res_carry_hold", res_carry, last_carry);
    end
  end

  always @(negedge clk) begin : mon_wr
    wr_t w;
    if (rf_we) begin
      if (wr_q.size() == 0) chk("rf_we_unexpected", 1, 0);
      else begin
        w = wr_q.pop_front();
        chk("rf_addr_rd", rf_addr_rd, w.a);
        chk("rf_data", rf_data, w.d);
      end
    end
  end

  task automatic garbage();
    cmd_op  = 2'($urandom_range(0, 3));
    cmd_rd  = AW'($urandom_range(0, 15));
    cmd_rs1 = AW'($urandom_range(0, 15));
    cmd_rs2 = AW'($urandom_range(0, 15));
    cmd_imm = DW'($urandom_range(0, 255));
  endtask

  // Called at a falling edge; leaves cmd_valid high with junk fields while busy.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] rd, rs1, rs2,
                       input logic [DW-1:0] imm, exp_d, input logic exp_c);
    int busy;
    int waitn = 0;
    while (!cmd_ready && waitn < 20) begin @(negedge clk); waitn++; end
    chk("ready_before_issue", cmd_ready, 1);
    busy = (op == 2'd0) ? 2 : 3;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    res_q.push_back('{exp_d, exp_c, cyc + 1, busy});
    if (rd != '0) wr_q.push_back('{rd, exp_d});
    @(posedge clk);
    for (int i = 0; i < busy; i++) begin
      @(negedge clk);
      garbage();
      chk("ready_busy", cmd_ready, 0);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_carry", res_carry, 0);
    chk("rst_rf_addr_rs1", rf_addr_rs1, 0);
    chk("rst_rf_addr_rs2", rf_addr_rs2, 0);
    chk("rst_rf_addr_rd", rf_addr_rd, 0);
    chk("rst_rf_data", rf_data, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    //     op    rd     rs1    rs2    imm     exp     carry
    issue(2'd0, 4'd3, 4'd0, 4'd0, 8'h5A, 8'h5A, 1'b0);   // LOAD r3
    issue(2'd0, 4'd1, 4'd0, 4'd0, 8'hF0, 8'hF0, 1'b0);
    issue(2'd0, 4'd2, 4'd0, 4'd0, 8'h20, 8'h20, 1'b0);
    issue(2'd1, 4'd4, 4'd1, 4'd2, 8'h00, 8'h10, 1'b1);   // F0+20
    issue(2'd0, 4'd1, 4'd0, 4'd0, 8'h05, 8'h05, 1'b0);
    issue(2'd0, 4'd2, 4'd0, 4'd0, 8'h07, 8'h07, 1'b0);
    issue(2'd2, 4'd5, 4'd1, 4'd2, 8'h00, 8'hFE, 1'b1);   // 05-07
    issue(2'd2, 4'd6, 4'd2, 4'd1, 8'h00, 8'h02, 1'b0);   // 07-05
    issue(2'd0, 4'd0, 4'd0, 4'd0, 8'h77, 8'h77, 1'b0);   // LOAD r0: no write
    issue(2'd3, 4'd7, 4'd3, 4'd9, 8'h00, 8'h5A, 1'b0);   // MOV r3
    issue(2'd1, 4'd3, 4'd3, 4'd3, 8'h00, 8'hB4, 1'b0);   // r3+r3 into r3
    issue(2'd1, 4'd3, 4'd3, 4'd3, 8'h00, 8'h68, 1'b1);   // B4+B4
    issue(2'd1, 4'd8, 4'd0, 4'd2, 8'h00, 8'h07, 1'b0);   // r0 reads zero

    // Abandon an ADD during READ; nothing may be written or reported.
    cmd_valid = 1'b1;
    cmd_op = 2'd1; cmd_rd = 4'd9; cmd_rs1 = 4'd1; cmd_rs2 = 4'd2; cmd_imm = 8'h00;
    @(posedge clk);
    @(negedge clk);
    garbage();
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    repeat (2) @(negedge clk);
    chk("rst_hold_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    issue(2'd0, 4'd10, 4'd0, 4'd0, 8'h3C, 8'h3C, 1'b0);  // first edge after release
    issue(2'd3, 4'd11, 4'd9, 4'd0, 8'h00, 8'h00, 1'b0);  // r9 never written
    issue(2'd3, 4'd12, 4'd10, 4'd0, 8'h00, 8'h3C, 1'b0);
    cmd_valid = 1'b0;

    repeat (6) @(negedge clk);
    chk("res_queue_drained", res_q.size(), 0);
    chk("wr_queue_drained", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
